// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V style control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing
// with combinational control decode, retired-instruction counter and sticky illegal flag.
module multicycle_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        reg_write,
    output logic        alu_src,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  mem_to_reg,
    output logic [15:0] instr_count,
    output logic        illegal,
    output logic        halted
);

    localparam int unsigned COUNT_W = 16;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_IMM    = 2'b01;
    localparam logic [1:0] PC_RS1IMM = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [COUNT_W-1:0]   count_q;
    logic                 illegal_q;
    logic                 retire;
    logic                 set_illegal;

    logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_sys;
    logic br_ok, br_taken;

    // Opcode class decode from the held instruction register
    always_comb begin
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_br    = (opcode == OP_BR);
        is_jal   = (opcode == OP_JAL);
        is_jalr  = (opcode == OP_JALR);
        is_sys   = (opcode == OP_SYS);
        br_ok    = is_br && ((funct3 == 3'b000) || (funct3 == 3'b001));
        br_taken = ((funct3 == 3'b000) && zero_flag) ||
                   ((funct3 == 3'b001) && !zero_flag);
    end

    // Next-state and control decode
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        pc_src      = PC_PLUS4;
        mem_to_reg  = WB_ALU;
        retire      = 1'b0;
        set_illegal = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_src = is_i || is_load || is_store || is_jalr;
                if (is_r || is_i || is_jal || is_jalr) begin
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (br_ok) begin
                    retire  = 1'b1;
                    pc_src  = br_taken ? PC_IMM : PC_PLUS4;
                    state_d = S_FETCH;
                end else begin
                    // SYS halts cleanly; everything else here is an illegal instruction
                    set_illegal = !is_sys;
                    state_d     = S_HALT;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load ? WB_MEM :
                             (is_jal || is_jalr) ? WB_LINK : WB_ALU;
                pc_src     = is_jal ? PC_IMM : (is_jalr ? PC_RS1IMM : PC_PLUS4);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset pre-empts retirement, so the PC is never written in a reset cycle
    always_comb begin
        pc_write    = retire && !reset;
        state       = state_q;
        halted      = (state_q == S_HALT);
        instr_count = count_q;
        illegal     = illegal_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + COUNT_W'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

endmodule
